vga_out_dither: RTL and testbench

//  Output stage directly downstream of rbzero. Registers the 6-bit RRGGBB pixel stream
//  and the active-low syncs, and reduces each 2-bit channel to 1 bit using 2x2 ordered
//  (Bayer) dithering keyed on hpos[0]/vpos[0]. Produces a timing-aligned 3-bit RGB
//  + sync bundle for 1-bit-per-channel VGA targets (TT pins, minimal FPGA DACs).

---
 rtl/vga_out_dither.sv | 118 +++++++++++
 tb/tb_vga_out_dither.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_out_dither.sv
// vga_out_dither: two-stage output pipe, 2x2 Bayer dither of 2-bit RGB channels to 1 bit.
// Optional macro TEMPORAL_DITHER_EN rotates the Bayer index by a per-frame phase.
`default_nettype none

module vga_out_dither (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dither_en,
  input  logic       i_hsync_n,
  input  logic       i_vsync_n,
  input  logic [5:0] i_rgb,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic [2:0] rgb,
  output logic [1:0] o_frame
);

  logic [5:0] s1_rgb;
  logic       s1_x;
  logic       s1_y;
  logic       s1_hsync_n;
  logic       s1_vsync_n;
  logic       s1_dither_en;
  logic [1:0] frame;
  logic [1:0] bayer_idx;
  logic [1:0] eff_idx;
  logic [2:0] rgb_next;
  logic       unused_pos;

  assign unused_pos = &{1'b0, i_hpos[9:1], i_vpos[9:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_rgb       <= 6'd0;
      s1_x         <= 1'b0;
      s1_y         <= 1'b0;
      s1_hsync_n   <= 1'b1;
      s1_vsync_n   <= 1'b1;
      s1_dither_en <= 1'b0;
    end else begin
      s1_rgb       <= i_rgb;
      s1_x         <= i_hpos[0];
      s1_y         <= i_vpos[0];
      s1_hsync_n   <= i_hsync_n;
      s1_vsync_n   <= i_vsync_n;
      s1_dither_en <= dither_en;
    end
  end

`ifdef TEMPORAL_DITHER_EN
  logic vsync_prev;

  // Count start-of-vsync events seen at stage 1; a held-low vsync counts once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev <= 1'b1;
      frame      <= 2'd0;
    end else begin
      vsync_prev <= s1_vsync_n;
      if (vsync_prev && !s1_vsync_n) begin
        frame <= frame + 2'd1;
      end
    end
  end
`else
  assign frame = 2'b00;
`endif

  assign o_frame = frame;

  always_comb begin
    bayer_idx = 2'd0;
    case ({s1_y, s1_x})
      2'b00:   bayer_idx = 2'd0;
      2'b01:   bayer_idx = 2'd2;
      2'b10:   bayer_idx = 2'd3;
      default: bayer_idx = 2'd1;
    endcase
  end

  assign eff_idx = bayer_idx + frame;

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    logic [1:0] c;
    logic [2:0] thresh;

    assign c = s1_rgb[2*ch +: 2];

    always_comb begin
      thresh = 3'd0;
      case (c)
        2'd0:    thresh = 3'd0;
        2'd1:    thresh = 3'd1;
        2'd2:    thresh = 3'd3;
        default: thresh = 3'd4;
      endcase
    end

    assign rgb_next[ch] = s1_dither_en ? ({1'b0, eff_idx} < thresh) : c[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb     <= 3'd0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else begin
      rgb     <= rgb_next;
      hsync_n <= s1_hsync_n;
      vsync_n <= s1_vsync_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_out_dither.sv
// tb_vga_out_dither: directed + random stimulus against a queue-based reference model.
`default_nettype none

module tb_vga_out_dither;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dither_en = 1'b0;
  logic       i_hsync_n = 1'b1;
  logic       i_vsync_n = 1'b1;
  logic [5:0] i_rgb = 6'd0;
  logic [9:0] i_hpos = 10'd0;
  logic [9:0] i_vpos = 10'd0;
  logic       hsync_n;
  logic       vsync_n;
  logic [2:0] rgb;
  logic [1:0] o_frame;

  vga_out_dither dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dither_en (dither_en),
    .i_hsync_n (i_hsync_n),
    .i_vsync_n (i_vsync_n),
    .i_rgb     (i_rgb),
    .i_hpos    (i_hpos),
    .i_vpos    (i_vpos),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .rgb       (rgb),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0] pix;
    logic       x;
    logic       y;
    logic       hs;
    logic       vs;
    logic       den;
  } sample_t;

  // Model: pixels waiting in the pipe, the last two vsync samples, and the
  // number of vsync falling edges counted so far.
  sample_t pending[$];
  logic    vs_last;
  logic    vs_before;
  int      frame_cnt;

  function automatic logic [2:0] ref_pixel(sample_t s, int frame);
    int bayer[4];
    int duty[4];
    int idx;
    logic [2:0] out;
    bayer[0] = 0; bayer[1] = 2; bayer[2] = 3; bayer[3] = 1;  // index = y*2 + x
    duty[0] = 0;  duty[1] = 1;  duty[2] = 3;  duty[3] = 4;
    idx = bayer[s.y * 2 + s.x];
`ifdef TEMPORAL_DITHER_EN
    idx = (idx + frame) % 4;
`endif
    for (int ch = 0; ch < 3; ch++) begin
      int c;
      c = (s.pix >> (2 * ch)) & 3;
      if (s.den) out[ch] = (idx < duty[c]);
      else       out[ch] = (c >= 2);
    end
    return out;
  endfunction

  function automatic logic [1:0] ref_frame();
`ifdef TEMPORAL_DITHER_EN
    return 2'(frame_cnt % 4);
`else
    return 2'd0;
`endif
  endfunction

  task automatic model_reset();
    sample_t r;
    r.pix = 6'd0; r.x = 1'b0; r.y = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.den = 1'b0;
    pending.delete();
    pending.push_back(r);
    vs_last   = 1'b1;
    vs_before = 1'b1;
    frame_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Caller is positioned just after a rising edge; drives, clocks, then checks.
  task automatic step(input logic [5:0] pix, input logic [9:0] h, input logic [9:0] v,
                      input logic hs, input logic vs, input logic den);
    sample_t s;
    sample_t out_s;
    logic [2:0] exp_rgb;
    i_rgb = pix; i_hpos = h; i_vpos = v; i_hsync_n = hs; i_vsync_n = vs; dither_en = den;
    s.pix = pix; s.x = h[0]; s.y = v[0]; s.hs = hs; s.vs = vs; s.den = den;
    @(posedge clk);
    out_s   = pending.pop_front();
    exp_rgb = ref_pixel(out_s, frame_cnt);
    if (vs_before && !vs_last) frame_cnt++;
    vs_before = vs_last;
    vs_last   = vs;
    pending.push_back(s);
    #1;
    check("rgb",     rgb,               exp_rgb);
    check("hsync_n", {2'b00, hsync_n},  {2'b00, out_s.hs});
    check("vsync_n", {2'b00, vsync_n},  {2'b00, out_s.vs});
    check("o_frame", {1'b0, o_frame},   {1'b0, ref_frame()});
  endtask

  task automatic async_reset_check();
    i_rgb = 6'h3F; i_hsync_n = 1'b0; i_vsync_n = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("rst_rgb",     rgb,              3'b000);
    check("rst_hsync_n", {2'b00, hsync_n}, 3'b001);
    check("rst_vsync_n", {2'b00, vsync_n}, 3'b001);
    check("rst_o_frame", {1'b0, o_frame},  3'b000);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [9:0] h;
    logic [9:0] v;
    logic       vs;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();

    // Activity, then asynchronous reset mid-line with full-white input.
    for (int i = 0; i < 6; i++) step(6'h3F, 10'(i), 10'd0, 1'b1, 1'b1, 1'b1);
    async_reset_check();
    step(6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(6'h3F, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1);
    step(6'h3F, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1);

    // 2x2 tile with R=2, G=1, B=0, dithering on.
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++)
        step(6'b10_01_00, 10'(x), 10'(y), 1'b1, 1'b1, 1'b1);

    // Truncation mode over the tile.
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++)
        step(6'b10_01_11, 10'(x), 10'(y), 1'b1, 1'b1, 1'b0);
    step(6'b10_01_11, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    step(6'b10_01_11, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    check("trunc_101", rgb, 3'b101);

    // Sync toggles interleaved with a pixel pattern; dither_en switching per pixel.
    for (int i = 0; i < 12; i++)
      step(6'(i * 7), 10'(i), 10'(i / 4), 1'((i % 3) != 0), 1'((i % 5) != 1), 1'(i % 2));

    // Vsync frames: four falling edges, one with vsync held low for several lines.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 3; i++) step(6'b01_01_01, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < ((f == 2) ? 9 : 2); i++)
        step(6'b01_01_01, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++)
          step(6'b01_10_01, 10'(x), 10'(y), 1'b1, 1'b1, 1'b1);
    end

    // Random raster-like traffic with one reset in the middle.
    h = 10'd0; v = 10'd0; vs = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset_check();
      if ($urandom_range(0, 15) == 0) vs = ~vs;
      step(6'($urandom), h, v, 1'($urandom_range(0, 7) != 0), vs,
           1'($urandom_range(0, 3) != 0));
      h = h + 10'd1;
      if (h == 10'd20) begin
        h = 10'd0;
        v = v + 10'd1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
